if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction fetch stage. Produces if_id_IR, if_id_PC and if_id_valid_inst for the decode stage, and obeys the decode stall.
- Owns the PC register and drives a request/response instruction-memory interface, with at most one request outstanding.
- Handles branch/jump redirects from EX by squashing in-flight fetches and injecting bubbles into IF/ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  system clock
- rst  in  1  system reset
- id_stall  in  1  decode-stage stall; IF/ID must hold when high
- ex_take_branch  in  1  redirect request from EX
- ex_target_pc  in  32  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address, word aligned
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  32  fetched instruction word
- if_id_IR  out  32  IF/ID instruction register
- if_id_PC  out  32  IF/ID PC register
- if_id_valid_inst  out  1  IF/ID entry valid
- if_pc_out  out  32  current fetch PC (debug)

Behaviour:
- Single clock clk. Reset rst is synchronous, active-high.
- Reset values:
  - pc = RESET_PC.
  - State = FETCH.
  - if_id_IR = NOP_INST, if_id_PC = 0, if_id_valid_inst = 0.
  - squash = 0, hold register cleared.
- States:
  - FETCH: issue a request.
  - WAIT: one request outstanding.
  - HOLD: response captured while decode is stalled.
- Request drive:
  - imem_req_valid = (state==FETCH) & ~ex_take_branch.
  - imem_req_addr = {pc[31:2], 2'b00}.
- FETCH: when the request is accepted (req_valid & req_ready), latch req_pc <= pc and go to WAIT. Otherwise stay in FETCH.
- WAIT, on imem_rsp_valid:
  - squash set: drop the data, clear squash, go to FETCH.
  - ~id_stall: load IF/ID = {rsp_data, req_pc, valid=1}, set pc <= req_pc+4, go to FETCH.
  - id_stall: capture {rsp_data, req_pc} in the hold register, go to HOLD.
- HOLD: when ~id_stall, load IF/ID from the hold register, set pc <= hold_pc+4, go to FETCH.
- IF/ID update rules:
  - If id_stall and no redirect, IF/ID holds its value.
  - If not stalled and no valid load this cycle, IF/ID gets a bubble: IR = NOP_INST, valid = 0, PC unchanged.
- Redirect (ex_take_branch=1) has highest priority and overrides id_stall:
  - pc <= {ex_target_pc[31:2], 2'b00}.
  - IF/ID <= bubble.
  - FETCH: no request is issued this cycle; stay in FETCH.
  - WAIT, no response this cycle: set squash and stay in WAIT.
  - WAIT, response in the same cycle: drop the response, go to FETCH.
  - HOLD: discard the held word, go to FETCH.
- Redirect arriving while squash is already set: squash stays set; pc takes the newest target.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- imem_rsp_valid outside WAIT is ignored.
- Reset mid-operation: all state returns to reset values. A later response from the pre-reset request is ignored, because state is FETCH.
- Latency: with a 1-cycle memory and no stalls, one instruction is delivered every 2 cycles.

Optional Feature:
- Macro: IF_PREFETCH_EN.
- With IF_PREFETCH_EN defined:
  - HOLD is replaced by a 2-entry FIFO of {IR, PC}.
  - Fetch keeps issuing requests while id_stall is high, until the FIFO is full (counting an outstanding request as an occupied slot).
  - pc advances on every accepted response; IF/ID loads from the FIFO head when ~id_stall.
  - A simultaneous push and pop is allowed when full.
  - Redirect flushes the FIFO and squashes any outstanding request.
- Without IF_PREFETCH_EN: the single-entry HOLD behaviour above applies.

Test Plan:
- Reset, then 1-cycle memory returning 0x00500093, 0x00A00113 -> imem_req_addr sequence 0x0, 0x4; IF/ID receives (0x00500093, PC 0x0, valid 1), then (0x00A00113, PC 0x4); a bubble (NOP, valid 0) appears between them.
- id_stall held for 3 cycles while a response arrives in WAIT -> IF/ID unchanged throughout; the held word loads on the first unstalled cycle; the next request goes to req_pc+4.
- Redirect to 0x100 while in WAIT with the response 2 cycles later -> response dropped, IF/ID bubble, next request address 0x100 with no extra issued requests.
- Redirect in the same cycle as imem_rsp_valid, and redirect during HOLD -> data discarded, IF/ID valid 0, next address equals the target.
- pc = 0xFFFFFFFC fetched -> next request address 0x00000000. ex_target_pc = 0x103 -> request address 0x100.
- IF_PREFETCH_EN: stall for 5 cycles with a 1-cycle memory -> exactly 2 words buffered and request issue stops; unstalling delivers both in order, one per cycle.

Source files
------------

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with PC, imem request/response port and IF/ID register
//
// Owns the fetch PC and keeps at most one instruction-memory request in flight.
// It feeds the IF/ID register, inserts bubbles when no word is ready, holds the
// register while decode stalls, and squashes in-flight fetches on an EX redirect.
//
// Optional build macro IF_PREFETCH_EN: the single HOLD slot is replaced by a
// 2-entry {IR, PC} FIFO, so fetching continues while decode is stalled.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_stall            decode stall; IF/ID holds while high (unless redirected)
//   ex_take_branch      redirect request from EX, highest priority
//   ex_target_pc        redirect target (low two bits ignored)
//   imem_req_valid/ready/addr   fetch request handshake, word-aligned address
//   imem_rsp_valid/data         fetch response
//   if_id_IR/PC/valid_inst      IF/ID pipeline register
//   if_pc_out           current fetch PC (debug)
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        ex_take_branch,
    input  logic [31:0] ex_target_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] if_id_IR,
    output logic [31:0] if_id_PC,
    output logic        if_id_valid_inst,
    output logic [31:0] if_pc_out
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        squash_q, squash_d;
    logic [31:0] if_id_ir_q, if_id_ir_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic        if_id_valid_q, if_id_valid_d;

`ifdef IF_PREFETCH_EN
    logic [31:0] fifo_ir_q [2];
    logic [31:0] fifo_ir_d [2];
    logic [31:0] fifo_pc_q [2];
    logic [31:0] fifo_pc_d [2];
    logic        fifo_rd_q, fifo_rd_d;
    logic [1:0]  fifo_cnt_q, fifo_cnt_d;
    logic        fifo_wr_idx;
    logic        push;
    logic        pop;
`else
    logic [31:0] hold_ir_q, hold_ir_d;
    logic [31:0] hold_pc_q, hold_pc_d;
`endif

    logic [31:0] redirect_pc;
    logic        req_fire;

    assign redirect_pc = {ex_target_pc[31:2], 2'b00};

`ifdef IF_PREFETCH_EN
    // In FETCH nothing is outstanding, so a free FIFO slot is all that is needed
    // to keep the outstanding request counted as an occupied slot.
    assign imem_req_valid = (state_q == FETCH) & ~ex_take_branch & (fifo_cnt_q != 2'd2);
`else
    assign imem_req_valid = (state_q == FETCH) & ~ex_take_branch;
`endif
    assign imem_req_addr    = {pc_q[31:2], 2'b00};
    assign req_fire         = imem_req_valid & imem_req_ready;
    assign if_id_IR         = if_id_ir_q;
    assign if_id_PC         = if_id_pc_q;
    assign if_id_valid_inst = if_id_valid_q;
    assign if_pc_out        = pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        squash_d      = squash_q;
        if_id_ir_d    = if_id_ir_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;
`ifdef IF_PREFETCH_EN
        fifo_ir_d   = fifo_ir_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_cnt_d  = fifo_cnt_q;
        fifo_wr_idx = fifo_rd_q ^ fifo_cnt_q[0];
        push        = 1'b0;
        pop         = 1'b0;
`else
        hold_ir_d = hold_ir_q;
        hold_pc_d = hold_pc_q;
`endif

        // Unstalled with nothing to deliver: bubble, PC field left alone.
        if (!id_stall) begin
            if_id_ir_d    = NOP_INST;
            if_id_valid_d = 1'b0;
        end

        if (ex_take_branch) begin
            pc_d          = redirect_pc;
            if_id_ir_d    = NOP_INST;
            if_id_valid_d = 1'b0;
            // A request still in flight must have its response dropped later;
            // a response arriving right now is simply ignored.
            if ((state_q == WAIT) && !imem_rsp_valid) begin
                squash_d = 1'b1;
            end else begin
                state_d  = FETCH;
                squash_d = 1'b0;
            end
`ifdef IF_PREFETCH_EN
            fifo_cnt_d = 2'd0;
`endif
        end else begin
            case (state_q)
                FETCH: begin
                    if (req_fire) begin
                        req_pc_d = pc_q;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state_d  = FETCH;
                        squash_d = 1'b0;
                        if (!squash_q) begin
`ifdef IF_PREFETCH_EN
                            pc_d = req_pc_q + 32'd4;
                            push = 1'b1;
`else
                            if (!id_stall) begin
                                if_id_ir_d    = imem_rsp_data;
                                if_id_pc_d    = req_pc_q;
                                if_id_valid_d = 1'b1;
                                pc_d          = req_pc_q + 32'd4;
                            end else begin
                                hold_ir_d = imem_rsp_data;
                                hold_pc_d = req_pc_q;
                                state_d   = HOLD;
                            end
`endif
                        end
                    end
                end
`ifndef IF_PREFETCH_EN
                HOLD: begin
                    if (!id_stall) begin
                        if_id_ir_d    = hold_ir_q;
                        if_id_pc_d    = hold_pc_q;
                        if_id_valid_d = 1'b1;
                        pc_d          = hold_pc_q + 32'd4;
                        state_d       = FETCH;
                    end
                end
`endif
                default: state_d = FETCH;
            endcase

`ifdef IF_PREFETCH_EN
            // Oldest word first; with an empty FIFO the response bypasses it
            // so the unstalled path keeps its 2-cycle cadence.
            if (!id_stall) begin
                if (fifo_cnt_q != 2'd0) begin
                    if_id_ir_d    = fifo_ir_q[fifo_rd_q];
                    if_id_pc_d    = fifo_pc_q[fifo_rd_q];
                    if_id_valid_d = 1'b1;
                    pop           = 1'b1;
                end else if (push) begin
                    if_id_ir_d    = imem_rsp_data;
                    if_id_pc_d    = req_pc_q;
                    if_id_valid_d = 1'b1;
                    push          = 1'b0;
                end
            end
            if (push) begin
                fifo_ir_d[fifo_wr_idx] = imem_rsp_data;
                fifo_pc_d[fifo_wr_idx] = req_pc_q;
            end
            fifo_rd_d  = fifo_rd_q ^ pop;
            fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            req_pc_q      <= 32'd0;
            squash_q      <= 1'b0;
            if_id_ir_q    <= NOP_INST;
            if_id_pc_q    <= 32'd0;
            if_id_valid_q <= 1'b0;
`ifdef IF_PREFETCH_EN
            fifo_ir_q  <= '{default: 32'd0};
            fifo_pc_q  <= '{default: 32'd0};
            fifo_rd_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
`else
            hold_ir_q <= 32'd0;
            hold_pc_q <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            squash_q      <= squash_d;
            if_id_ir_q    <= if_id_ir_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
`ifdef IF_PREFETCH_EN
            fifo_ir_q  <= fifo_ir_d;
            fifo_pc_q  <= fifo_pc_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
`else
            hold_ir_q <= hold_ir_d;
            hold_pc_q <= hold_pc_d;
`endif
        end
    end

endmodule
